opb_status_poller: RTL and testbench

//  OPB bus master that periodically reads one 32-bit software-status slave

---
 rtl/opb_master_pkg.sv | 39 +++
 rtl/opb_status_poller_if.sv | 28 ++
 rtl/opb_poll_timer.sv | 75 +++++++
 rtl/opb_status_poller.sv | 151 +++++++++++++++
 tb/tb_opb_status_poller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_master_pkg.sv
// Shared OPB master definitions: FSM states, response priority resolution,
// and the [0:31] big-endian bus to [31:0] little-endian bit reversal.
package opb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } opb_state_e;

  // Slave responses seen in XFER, listed highest priority first
  typedef enum logic [2:0] {
    RSP_NONE  = 3'd0,
    RSP_ERR   = 3'd1,
    RSP_ACK   = 3'd2,
    RSP_TMO   = 3'd3,
    RSP_RETRY = 3'd4
  } opb_rsp_e;

  // Collapse simultaneous responses to the single one that wins this cycle
  function automatic opb_rsp_e opb_resolve(input logic err_ack, input logic xfer_ack,
                                           input logic tmo, input logic retry);
    if (err_ack)       return RSP_ERR;
    else if (xfer_ack) return RSP_ACK;
    else if (tmo)      return RSP_TMO;
    else if (retry)    return RSP_RETRY;
    else               return RSP_NONE;
  endfunction

  // OPB bit 0 is the MSB; result bit i takes bus bit 31-i
  function automatic logic [31:0] opb_bitrev(input logic [0:31] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_status_poller_if.sv
// OPB master-side bus bundle.
//   master modport: drives M_* request/transfer signals, receives OPB_* responses
//   slave  modport: arbiter/slave view, the mirror image
interface opb_status_poller_if;
  logic        M_request;
  logic        OPB_MGrant;
  logic        M_select;
  logic        M_RNW;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        M_seqAddr;
  logic [0:31] OPB_DBus;
  logic        OPB_xferAck;
  logic        OPB_errAck;
  logic        OPB_retry;
  logic        OPB_timeout;

  modport master (
    output M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout
  );

  modport slave (
    input  M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout
  );
endinterface

// File: rtl/opb_poll_timer.sv
// Poll launch generator: period counter, one-deep pending slot, missed counter.
//   OPB_Clk/OPB_Rst : clock, synchronous active-high reset
//   poll_en         : lets the period counter run
//   poll_now        : immediate launch request
//   fsm_idle        : poller FSM is in IDLE this cycle
//   start_c         : combinational, FSM should leave IDLE now
//   missed_count    : saturating count of launches dropped while busy
module opb_poll_timer #(
  parameter int unsigned C_POLL_PERIOD = 1024
) (
  input  logic       OPB_Clk,
  input  logic       OPB_Rst,
  input  logic       poll_en,
  input  logic       poll_now,
  input  logic       fsm_idle,
  output logic       start_c,
  output logic [7:0] missed_count
);

  localparam int unsigned CNT_W = $clog2(C_POLL_PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic [7:0]       missed_q, missed_d;
  logic             tick;
  logic             launch;

  // Period tick, launch merge, and pending/missed bookkeeping
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    missed_d  = missed_q;
    tick      = 1'b0;
    start_c   = 1'b0;
    launch    = 1'b0;

    if (poll_en) begin
      if (cnt_q == CNT_W'(C_POLL_PERIOD - 1)) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    launch = tick | poll_now;

    // A launch arriving together with a queued one in IDLE merges into one poll
    if (fsm_idle) begin
      start_c   = launch | pending_q;
      pending_d = 1'b0;
    end else if (launch) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (missed_q != 8'hFF) begin
        missed_d = missed_q + 8'd1;
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      missed_q  <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign missed_count = missed_q;

endmodule

// File: rtl/opb_status_poller.sv
// OPB read master that periodically fetches one status register.
//   OPB_Clk/OPB_Rst : clock, synchronous active-high reset
//   opb             : OPB master bus bundle (request/grant, select, address, responses)
//   poll_en         : enable periodic polling
//   poll_now        : one-cycle pulse, poll immediately
//   status_data     : last successfully read word, LSB-0 ordering
//   status_valid    : one-cycle pulse when status_data updates
//   err_flag        : sticky error (errAck, timeout, retry exhaustion)
//   missed_count    : saturating count of launches dropped while busy
module opb_status_poller
  import opb_master_pkg::*;
#(
  parameter logic [31:0] C_TARGET_ADDR = 32'h0108_0100,
  parameter int unsigned C_POLL_PERIOD = 1024,
  parameter int unsigned C_TIMEOUT     = 16,
  parameter int unsigned C_MAX_RETRY   = 4
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  opb_status_poller_if.master        opb,
  input  logic                       poll_en,
  input  logic                       poll_now,
  output logic [31:0]                status_data,
  output logic                       status_valid,
  output logic                       err_flag,
  output logic [7:0]                 missed_count
);

  localparam int unsigned TMO_W = $clog2(C_TIMEOUT + 1);
  localparam int unsigned RTY_W = $clog2(C_MAX_RETRY + 1);

  opb_state_e       state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0] rty_cnt_q, rty_cnt_d;
  logic             req_q, req_d;
  logic             sel_q, sel_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             start_c;
  logic             tmo_hit;
  opb_rsp_e         rsp;

  opb_poll_timer #(
    .C_POLL_PERIOD (C_POLL_PERIOD)
  ) u_timer (
    .OPB_Clk      (OPB_Clk),
    .OPB_Rst      (OPB_Rst),
    .poll_en      (poll_en),
    .poll_now     (poll_now),
    .fsm_idle     (state_q == ST_IDLE),
    .start_c      (start_c),
    .missed_count (missed_count)
  );

  // Next-state, response handling and data capture
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    rty_cnt_d = rty_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    tmo_hit   = opb.OPB_timeout || (tmo_cnt_q == TMO_W'(C_TIMEOUT - 1));
    rsp       = opb_resolve(opb.OPB_errAck, opb.OPB_xferAck, tmo_hit, opb.OPB_retry);

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d   = ST_REQ;
          rty_cnt_d = '0;
        end
      end
      ST_REQ: begin
        if (opb.OPB_MGrant) begin
          state_d   = ST_XFER;
          tmo_cnt_d = '0;
        end
      end
      ST_XFER: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        case (rsp)
          RSP_ERR: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
          RSP_ACK: begin
            data_d  = opb_bitrev(opb.OPB_DBus);
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
          RSP_TMO: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
          RSP_RETRY: begin
            // C_MAX_RETRY retries re-request; the next one gives up
            if (rty_cnt_q == RTY_W'(C_MAX_RETRY)) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rty_cnt_d = rty_cnt_q + RTY_W'(1);
              state_d   = ST_REQ;
            end
          end
          default: ;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    req_d = (state_d == ST_REQ);
    sel_d = (state_d == ST_XFER);
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      rty_cnt_q <= '0;
      req_q     <= 1'b0;
      sel_q     <= 1'b0;
      data_q    <= 32'h0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      rty_cnt_q <= rty_cnt_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Address/BE are gated by the select flop so they read 0 outside a transfer
  assign opb.M_request = req_q;
  assign opb.M_select  = sel_q;
  assign opb.M_RNW     = sel_q;
  assign opb.M_ABus    = sel_q ? C_TARGET_ADDR : 32'h0;
  assign opb.M_BE      = sel_q ? 4'hF : 4'h0;
  assign opb.M_DBus    = 32'h0;
  assign opb.M_seqAddr = 1'b0;

  assign status_data  = data_q;
  assign status_valid = valid_q;
  assign err_flag     = err_q;

endmodule

// File: tb/tb_opb_status_poller.sv
// Directed bench for opb_status_poller with a status_valid scoreboard.
module tb_opb_status_poller;

  localparam logic [31:0] TARGET = 32'h0108_0100;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic        poll_en;
  logic        poll_now;
  logic [31:0] status_data;
  logic        status_valid;
  logic        err_flag;
  logic [7:0]  missed_count;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  opb_status_poller_if bus ();

  opb_status_poller dut (
    .OPB_Clk      (OPB_Clk),
    .OPB_Rst      (OPB_Rst),
    .opb          (bus),
    .poll_en      (poll_en),
    .poll_now     (poll_now),
    .status_data  (status_data),
    .status_valid (status_valid),
    .err_flag     (err_flag),
    .missed_count (missed_count)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  always @(posedge OPB_Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each status_valid pulse must match the oldest expected word
  always @(negedge OPB_Clk) begin
    if (status_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(status_valid), 32'h0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_status_data", status_data, sb_exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_req(input int limit, output int waited);
    waited = 0;
    while (bus.M_request !== 1'b1 && waited < limit) begin
      @(negedge OPB_Clk);
      waited++;
    end
    check("req_seen", 32'(bus.M_request), 32'h1);
  endtask

  // Grant two cycles after the request is seen, then confirm XFER
  task automatic grant();
    repeat (2) @(negedge OPB_Clk);
    bus.OPB_MGrant = 1'b1;
    @(negedge OPB_Clk);
    bus.OPB_MGrant = 1'b0;
    check("xfer_select", 32'(bus.M_select), 32'h1);
    check("xfer_req_low", 32'(bus.M_request), 32'h0);
  endtask

  task automatic ack(input logic [31:0] data);
    bus.OPB_DBus    = data;
    bus.OPB_xferAck = 1'b1;
    exp_q.push_back(data);
    @(negedge OPB_Clk);
    bus.OPB_xferAck = 1'b0;
    bus.OPB_DBus    = 32'h0;
  endtask

  task automatic launch_now();
    poll_now = 1'b1;
    @(negedge OPB_Clk);
    poll_now = 1'b0;
    check("poll_now_req", 32'(bus.M_request), 32'h1);
  endtask

  task automatic reset_pulse();
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_request"}, 32'(bus.M_request), 32'h0);
    check({pfx, "_select"},  32'(bus.M_select), 32'h0);
    check({pfx, "_rnw"},     32'(bus.M_RNW), 32'h0);
    check({pfx, "_abus"},    bus.M_ABus, 32'h0);
    check({pfx, "_be"},      32'(bus.M_BE), 32'h0);
    check({pfx, "_data"},    status_data, 32'h0);
    check({pfx, "_valid"},   32'(status_valid), 32'h0);
    check({pfx, "_err"},     32'(err_flag), 32'h0);
    check({pfx, "_missed"},  32'(missed_count), 32'h0);
  endtask

  initial begin
    int          n;
    int          re;
    bit          done;
    int unsigned t0;

    OPB_Rst          = 1'b1;
    poll_en          = 1'b0;
    poll_now         = 1'b0;
    bus.OPB_MGrant   = 1'b0;
    bus.OPB_DBus     = 32'h0;
    bus.OPB_xferAck  = 1'b0;
    bus.OPB_errAck   = 1'b0;
    bus.OPB_retry    = 1'b0;
    bus.OPB_timeout  = 1'b0;
    repeat (3) @(negedge OPB_Clk);

    // Reset state
    check_all_zero("rst");
    check("rst_dbus",    bus.M_DBus, 32'h0);
    check("rst_seqaddr", 32'(bus.M_seqAddr), 32'h0);
    OPB_Rst = 1'b0;

    // Nominal periodic poll
    poll_en = 1'b1;
    wait_req(1100, n);
    check("first_launch_cycles", 32'(n), 32'd1024);
    t0 = cyc;
    grant();
    check("xfer_abus", bus.M_ABus, TARGET);
    check("xfer_be",   32'(bus.M_BE), 32'hF);
    check("xfer_rnw",  32'(bus.M_RNW), 32'h1);
    check("xfer_dbus", bus.M_DBus, 32'h0);
    ack(32'h8000_0001);
    check("nom_valid",  32'(status_valid), 32'h1);
    check("nom_data",   status_data, 32'h8000_0001);
    check("nom_sel_dn", 32'(bus.M_select), 32'h0);
    check("nom_err",    32'(err_flag), 32'h0);
    @(negedge OPB_Clk);
    check("nom_valid_once", 32'(status_valid), 32'h0);

    // Second periodic poll: three retries then success
    wait_req(1100, n);
    check("poll_period", 32'(cyc - t0), 32'd1024);
    grant();
    for (int i = 0; i < 3; i++) begin
      bus.OPB_retry = 1'b1;
      @(negedge OPB_Clk);
      bus.OPB_retry = 1'b0;
      check("retry3_rereq", 32'(bus.M_request), 32'h1);
      grant();
    end
    ack(32'h1234_5678);
    check("retry3_data", status_data, 32'h1234_5678);
    check("retry3_err",  32'(err_flag), 32'h0);
    poll_en = 1'b0;

    // errAck and xferAck together: error wins, no capture
    repeat (2) @(negedge OPB_Clk);
    launch_now();
    grant();
    bus.OPB_DBus    = 32'hDEAD_BEEF;
    bus.OPB_errAck  = 1'b1;
    bus.OPB_xferAck = 1'b1;
    @(negedge OPB_Clk);
    bus.OPB_errAck  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_DBus    = 32'h0;
    check("errack_err",   32'(err_flag), 32'h1);
    check("errack_data",  status_data, 32'h1234_5678);
    check("errack_valid", 32'(status_valid), 32'h0);
    check("errack_sel",   32'(bus.M_select), 32'h0);

    // err_flag cleared only by reset
    reset_pulse();
    check("rstclr_err",  32'(err_flag), 32'h0);
    check("rstclr_data", status_data, 32'h0);

    // Retry exhaustion
    launch_now();
    grant();
    re   = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      bus.OPB_retry = 1'b1;
      @(negedge OPB_Clk);
      bus.OPB_retry = 1'b0;
      if (bus.M_request === 1'b1) begin
        re++;
        grant();
      end else begin
        done = 1'b1;
      end
    end
    check("retry_rerequests", 32'(re), 32'd4);
    check("retry_err",        32'(err_flag), 32'h1);
    check("retry_idle_sel",   32'(bus.M_select), 32'h0);
    check("retry_idle_req",   32'(bus.M_request), 32'h0);

    // Ack timeout
    reset_pulse();
    launch_now();
    grant();
    n    = 1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge OPB_Clk);
      if (bus.M_select === 1'b1) n++;
      else done = 1'b1;
    end
    check("timeout_sel_cycles", 32'(n), 32'd16);
    check("timeout_err",        32'(err_flag), 32'h1);

    // Grant withheld over three periods, then the queued poll
    reset_pulse();
    poll_en = 1'b1;
    wait_req(1100, n);
    repeat (3072) @(negedge OPB_Clk);
    check("withheld_missed", 32'(missed_count), 32'd2);
    check("withheld_req",    32'(bus.M_request), 32'h1);
    poll_en = 1'b0;
    grant();
    ack(32'hA5A5_0F0F);
    check("queued_idle_req", 32'(bus.M_request), 32'h0);
    @(negedge OPB_Clk);
    check("queued_poll_req", 32'(bus.M_request), 32'h1);
    grant();

    // Reset in the middle of a transfer
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);
    check_all_zero("midrst");
    OPB_Rst = 1'b0;
    repeat (5) @(negedge OPB_Clk);
    check("post_rst_idle", 32'(bus.M_request), 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
